// File: rtl/tdm_pkg.sv
// Shared constants, FSM state type and channel slice helper for the TDM demux.
// Pure definitions; no latency or flow control.
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    HUNT,
    RUN
  } tdm_state_e;

  // Low bit index of channel c inside a packed NUM_CH*w output word.
  function automatic int ch_lo(input int c, input int w);
    return c * w;
  endfunction

endpackage

// File: rtl/tdm_demux4_slot_dec2to4.sv
// 2-to-4 one-hot slot decoder; all-zero while enable is low.
// Combinational, zero latency; no flow control.
module slot_dec2to4 (
  input  logic [1:0] slot,
  input  logic       enable,
  output logic [3:0] onehot
);

  assign onehot = enable ? (4'b0001 << slot) : 4'b0000;

endmodule

// File: rtl/tdm_demux4.sv
// 1-bit TDM stream to four parallel WIDTH-bit words; valid pulses 1 clk after the last bit.
// No backpressure: en paces the line, words are presented once with a single-cycle valid.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sync,
  input  logic                    din,
  output logic [NUM_CH*WIDTH-1:0] dout,
  output logic                    dout_valid,
  output logic [NUM_CH-1:0]       slot_dec,
  output logic                    locked,
  output logic                    sync_err
);

  localparam int BC_W = $clog2(WIDTH);

  tdm_state_e        state;
  logic [SLOT_W-1:0] slot;
  logic [BC_W-1:0]   bitcnt;
  logic [WIDTH-1:0]  sh [NUM_CH];
  logic [NUM_CH-1:0] slot_oh;

  assign locked   = (state == RUN);
  assign slot_dec = slot_oh;

  // One decode serves both the observable slot and the shift-register enables.
  slot_dec2to4 u_dec (
    .slot   (slot),
    .enable (locked),
    .onehot (slot_oh)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      slot       <= '0;
      bitcnt     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) sh[c] <= '0;
    end else begin
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
      if (en) begin
        case (state)
          HUNT: begin
            if (sync) begin
              sh[0]  <= {{(WIDTH-1){1'b0}}, din};
              slot   <= SLOT_W'(1);
              bitcnt <= '0;
              state  <= RUN;
            end
          end
          RUN: begin
            if (sync && (slot != '0)) begin
              // Realign: the sync sample becomes slot 0 of a fresh word.
              sync_err <= 1'b1;
              for (int c = 1; c < NUM_CH; c++) sh[c] <= '0;
              sh[0]  <= {{(WIDTH-1){1'b0}}, din};
              slot   <= SLOT_W'(1);
              bitcnt <= '0;
            end else begin
              for (int c = 0; c < NUM_CH; c++) begin
                if (slot_oh[c]) sh[c] <= {sh[c][WIDTH-2:0], din};
              end
              slot <= slot + 1'b1;
              if (slot == SLOT_W'(NUM_CH-1)) begin
                if (bitcnt == BC_W'(WIDTH-1)) begin
                  for (int c = 0; c < NUM_CH-1; c++) begin
                    dout[ch_lo(c, WIDTH) +: WIDTH] <= sh[c];
                  end
                  dout[ch_lo(NUM_CH-1, WIDTH) +: WIDTH] <= {sh[NUM_CH-1][WIDTH-2:0], din};
                  dout_valid <= 1'b1;
                  bitcnt     <= '0;
                end else begin
                  bitcnt <= bitcnt + 1'b1;
                end
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (WIDTH=8): reset, nominal, gapped, misaligned sync,
// HUNT filtering and reset mid-word, with hand-computed expected words.
module tb_tdm_demux4;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          sync = 1'b0;
  logic          din = 1'b0;
  logic [4*W-1:0] dout;
  logic          dout_valid;
  logic [3:0]    slot_dec;
  logic          locked;
  logic          sync_err;

  int total = 0;
  int bad = 0;
  int vcnt;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sync       (sync),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slot_dec   (slot_dec),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic s, input logic d);
    en = e;
    sync = s;
    din = d;
    @(posedge clk);
    #1;
  endtask

  // Sends n samples of the interleaved words, MSB first; optional random en=0 gaps.
  task automatic send(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                      input logic [7:0] w3, input int n, input bit first_sync, input int gap_pct,
                      input logic [3:0] dec0, input bit err0, output int vc);
    logic [7:0] wd [4];
    logic [4*W-1:0] held;
    logic [3:0] exp_dec;
    int s;
    int b;
    wd[0] = w0; wd[1] = w1; wd[2] = w2; wd[3] = w3;
    vc = 0;
    for (int i = 0; i < n; i++) begin
      s = i % 4;
      b = i / 4;
      exp_dec = (i == 0) ? dec0 : (4'b0001 << s);
      for (int g = 0; g < 3; g++) begin
        if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
          held = dout;
          step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          chk("gap_dout_held", dout, held);
          chk("gap_valid_low", dout_valid, 1'b0);
          chk("gap_slot_dec", slot_dec, exp_dec);
        end
      end
      chk("slot_dec", slot_dec, exp_dec);
      step(1'b1, first_sync && (i == 0), wd[s][7-b]);
      chk("sync_err", sync_err, (i == 0) && err0);
      if (dout_valid) vc++;
    end
  endtask

  initial begin
    // 1. Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("rst_dout", dout, 0);
      chk("rst_valid", dout_valid, 1'b0);
      chk("rst_locked", locked, 1'b0);
      chk("rst_slot_dec", slot_dec, 4'b0000);
      chk("rst_sync_err", sync_err, 1'b0);
    end
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // 2. Nominal frame
    send(8'hA5, 8'h3C, 8'hFF, 8'h01, 32, 1'b1, 0, 4'b0000, 1'b0, vcnt);
    chk("nom_valid_last", dout_valid, 1'b1);
    chk("nom_dout", dout, 32'h01FF3CA5);
    chk("nom_vcnt", vcnt, 1);
    chk("nom_locked", locked, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("nom_valid_drop", dout_valid, 1'b0);
    chk("nom_dout_hold", dout, 32'h01FF3CA5);

    // 3. Gapped strobe, same data
    send(8'hA5, 8'h3C, 8'hFF, 8'h01, 32, 1'b1, 30, 4'b0001, 1'b0, vcnt);
    chk("gap_valid_last", dout_valid, 1'b1);
    chk("gap_dout", dout, 32'h01FF3CA5);
    chk("gap_vcnt", vcnt, 1);
    step(1'b0, 1'b0, 1'b0);

    // 4. Misaligned sync after 10 samples; the sync sample opens a new frame
    send(8'h00, 8'h00, 8'h00, 8'h00, 10, 1'b0, 0, 4'b0001, 1'b0, vcnt);
    chk("mis_pre_vcnt", vcnt, 0);
    send(8'h11, 8'h22, 8'h33, 8'h44, 32, 1'b1, 0, 4'b0100, 1'b1, vcnt);
    chk("mis_valid_last", dout_valid, 1'b1);
    chk("mis_dout", dout, 32'h44332211);
    chk("mis_vcnt", vcnt, 1);
    chk("mis_locked", locked, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // 5. HUNT filtering
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("hunt_locked", locked, 1'b0);
      chk("hunt_slot_dec", slot_dec, 4'b0000);
      chk("hunt_valid", dout_valid, 1'b0);
    end
    chk("hunt_dout", dout, 0);
    send(8'h5A, 8'hC3, 8'h0F, 8'h96, 32, 1'b1, 0, 4'b0000, 1'b0, vcnt);
    chk("hunt_valid_last", dout_valid, 1'b1);
    chk("hunt_frame_dout", dout, 32'h960FC35A);
    chk("hunt_vcnt", vcnt, 1);
    step(1'b0, 1'b0, 1'b0);

    // 6. Reset mid-word
    send(8'hDE, 8'hAD, 8'hBE, 8'hEF, 17, 1'b1, 0, 4'b0001, 1'b0, vcnt);
    chk("mid_partial_vcnt", vcnt, 0);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_locked", locked, 1'b0);
    chk("mid_rst_slot_dec", slot_dec, 4'b0000);
    send(8'hDE, 8'hAD, 8'hBE, 8'hEF, 32, 1'b1, 0, 4'b0000, 1'b0, vcnt);
    chk("mid_valid_last", dout_valid, 1'b1);
    chk("mid_dout", dout, 32'hEFBEADDE);
    chk("mid_vcnt", vcnt, 1);
    step(1'b0, 1'b0, 1'b0);
    chk("mid_valid_drop", dout_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
